// File: rtl/thermal_sched.sv
// Thermal-aware job scheduler: dispatches each job to the coolest idle, unthrottled core
// and pauses cores whose temperature crosses a hysteresis band.
module thermal_sched #(
  parameter int NCORES = 3,
  parameter int TEMP_W = 8,
  parameter int DUR_W  = 8,
  parameter int TRIP   = 90,
  parameter int RESUME = 80
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [DUR_W-1:0]         job_dur,
  input  logic [NCORES*TEMP_W-1:0] temperature,
  output logic [NCORES-1:0]        in_use,
  output logic [NCORES-1:0]        throttled,
  output logic [NCORES-1:0]        done_pulse,
  output logic                     halted
);

  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [TEMP_W-1:0] TRIP_T   = TEMP_W'(TRIP);
  localparam logic [TEMP_W-1:0] RESUME_T = TEMP_W'(RESUME);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NCORES - 1);

  typedef enum logic {RUN, HALT} state_e;

  state_e             state_q, state_d;
  logic [DUR_W-1:0]   cnt_q [NCORES];
  logic [DUR_W-1:0]   cnt_d [NCORES];
  logic [NCORES-1:0]  busy_q, busy_d;
  logic [NCORES-1:0]  thr_q, thr_d;
  logic [NCORES-1:0]  done_q, done_d;
  logic [PTR_W-1:0]   rr_q, rr_d;

  logic [TEMP_W-1:0]  tempW [NCORES];
  logic [NCORES-1:0]  eligible;
  logic               handshake;
  logic               found;
  logic [PTR_W-1:0]   chosen;
  logic [TEMP_W-1:0]  bestTemp;
  logic [DUR_W-1:0]   durEff;
  int                 idx;

  always_comb begin
    for (int k = 0; k < NCORES; k++) begin
      tempW[k] = temperature[k*TEMP_W +: TEMP_W];
    end
  end

  assign eligible   = ~busy_q & ~thr_q;
  assign in_use     = busy_q & ~thr_q;
  assign throttled  = thr_q;
  assign done_pulse = done_q;
  assign halted     = (state_q == HALT);
  assign job_ready  = (state_q == RUN) && (|eligible);
  assign handshake  = job_valid & job_ready;
  assign durEff     = (job_dur == '0) ? DUR_W'(1) : job_dur;

  // Scan starting at rr_q; strict less-than keeps the first core found on a temperature tie.
  always_comb begin
    found    = 1'b0;
    chosen   = '0;
    bestTemp = '0;
    idx      = 0;
    for (int i = 0; i < NCORES; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NCORES) idx = idx - NCORES;
      if (eligible[idx] && (!found || tempW[idx] < bestTemp)) begin
        found    = 1'b1;
        chosen   = PTR_W'(idx);
        bestTemp = tempW[idx];
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    thr_d  = thr_q;
    done_d = '0;
    rr_d   = rr_q;
    for (int k = 0; k < NCORES; k++) begin
      if (in_use[k]) begin
        if (cnt_q[k] == DUR_W'(1)) begin
          cnt_d[k]  = '0;
          busy_d[k] = 1'b0;
          done_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - DUR_W'(1);
        end
      end
      if (tempW[k] >= TRIP_T) begin
        thr_d[k] = 1'b1;
      end else if (tempW[k] < RESUME_T) begin
        thr_d[k] = 1'b0;
      end
    end
    if (handshake) begin
      cnt_d[chosen]  = durEff;
      busy_d[chosen] = 1'b1;
      rr_d           = (chosen == LAST_IDX) ? '0 : chosen + PTR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (&thr_q)  state_d = HALT;
      HALT:    if (~&thr_q) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      busy_q  <= '0;
      thr_q   <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      for (int k = 0; k < NCORES; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      thr_q   <= thr_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      for (int k = 0; k < NCORES; k++) cnt_q[k] <= cnt_d[k];
    end
  end

endmodule

// File: tb/tb_thermal_sched.sv
// Bench for thermal_sched: directed scenarios plus randomized traffic, all checked against
// a per-core job/temperature model that tracks remaining work as plain integers.
module tb_thermal_sched;

  localparam int N      = 3;
  localparam int TRIP   = 90;
  localparam int RESUME = 80;

  logic           CLK;
  logic           nRST;
  logic           job_valid;
  logic           job_ready;
  logic [7:0]     job_dur;
  logic [N*8-1:0] temperature;
  logic [N-1:0]   in_use;
  logic [N-1:0]   throttled;
  logic [N-1:0]   done_pulse;
  logic           halted;

  int checks = 0;
  int errors = 0;

  int tempIn [N];
  int remaining [N];
  bit hot [N];
  bit doneM [N];
  int rr;
  bit haltM;

  thermal_sched #(.NCORES(N), .TEMP_W(8), .DUR_W(8), .TRIP(TRIP), .RESUME(RESUME)) dut (
    .CLK(CLK), .nRST(nRST), .job_valid(job_valid), .job_ready(job_ready),
    .job_dur(job_dur), .temperature(temperature), .in_use(in_use),
    .throttled(throttled), .done_pulse(done_pulse), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit modelReady();
    bit any = 0;
    for (int k = 0; k < N; k++) if (remaining[k] == 0 && !hot[k]) any = 1;
    return !haltM && any;
  endfunction

  function automatic logic [N-1:0] modelInUse();
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = (remaining[k] > 0) && !hot[k];
    return v;
  endfunction

  function automatic logic [N-1:0] packBits(input bit b [N]);
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = b[k];
    return v;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < N; k++) begin
      remaining[k] = 0;
      hot[k] = 0;
      doneM[k] = 0;
    end
    rr = 0;
    haltM = 0;
  endtask

  // What the scheduler should do at one rising edge, given the inputs held across it.
  task automatic modelEdge(input bit v, input int dur);
    bit hs = v && modelReady();
    int best = -1;
    bit allHot = 1;
    for (int i = 0; i < N; i++) begin
      int k = (rr + i) % N;
      if (remaining[k] == 0 && !hot[k] && (best < 0 || tempIn[k] < tempIn[best])) best = k;
    end
    for (int k = 0; k < N; k++) if (!hot[k]) allHot = 0;
    for (int k = 0; k < N; k++) begin
      doneM[k] = 0;
      if (remaining[k] > 0 && !hot[k]) begin
        remaining[k]--;
        if (remaining[k] == 0) doneM[k] = 1;
      end
    end
    if (hs) begin
      remaining[best] = (dur == 0) ? 1 : dur;
      rr = (best + 1) % N;
    end
    for (int k = 0; k < N; k++) begin
      if (tempIn[k] >= TRIP) hot[k] = 1;
      else if (tempIn[k] < RESUME) hot[k] = 0;
    end
    if (!haltM && allHot) haltM = 1;
    else if (haltM && !allHot) haltM = 0;
  endtask

  task automatic compareAll();
    checkOutput("job_ready", 32'(job_ready), 32'(modelReady()));
    checkOutput("in_use", 32'(in_use), 32'(modelInUse()));
    checkOutput("throttled", 32'(throttled), 32'(packBits(hot)));
    checkOutput("done_pulse", 32'(done_pulse), 32'(packBits(doneM)));
    checkOutput("halted", 32'(halted), 32'(haltM));
  endtask

  task automatic setTemps(input int t0, input int t1, input int t2);
    tempIn[0] = t0;
    tempIn[1] = t1;
    tempIn[2] = t2;
  endtask

  // Called just after a falling edge: drive, cross one rising edge, check on the next falling edge.
  task automatic applyStimulus(input bit v, input int dur);
    job_valid = v;
    job_dur = 8'(dur);
    for (int k = 0; k < N; k++) temperature[k*8 +: 8] = 8'(tempIn[k]);
    @(posedge CLK);
    modelEdge(v, dur);
    @(negedge CLK);
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0);
  endtask

  task automatic doReset();
    job_valid = 0;
    #2;
    nRST = 0;
    #1;
    checkOutput("rst in_use", 32'(in_use), 32'd0);
    checkOutput("rst throttled", 32'(throttled), 32'd0);
    checkOutput("rst done_pulse", 32'(done_pulse), 32'd0);
    checkOutput("rst halted", 32'(halted), 32'd0);
    @(negedge CLK);
    nRST = 1;
    modelClear();
    checkOutput("rst job_ready", 32'(job_ready), 32'd1);
  endtask

  initial begin
    nRST = 0;
    job_valid = 0;
    job_dur = '0;
    setTemps(40, 40, 40);
    temperature = {8'd40, 8'd40, 8'd40};
    modelClear();
    @(negedge CLK);
    doReset();

    setTemps(40, 40, 40);
    applyStimulus(1, 5);
    checkOutput("s1 core0 taken", 32'(in_use), 32'b001);
    idle(4);
    checkOutput("s1 still running", 32'(in_use[0]), 32'd1);
    idle(1);
    checkOutput("s1 done strobe", 32'(done_pulse), 32'b001);
    idle(1);

    doReset();
    setTemps(60, 30, 30);
    applyStimulus(1, 10);
    checkOutput("s2 first core1", 32'(in_use), 32'b010);
    applyStimulus(1, 10);
    checkOutput("s2 second core2", 32'(in_use), 32'b110);
    idle(2);

    doReset();
    setTemps(40, 40, 40);
    applyStimulus(1, 5);
    idle(1);
    setTemps(95, 40, 40);
    applyStimulus(0, 0);
    checkOutput("s3 throttled0", 32'(throttled[0]), 32'd1);
    checkOutput("s3 paused0", 32'(in_use[0]), 32'd0);
    idle(2);
    setTemps(85, 40, 40);
    idle(3);
    checkOutput("s3 hysteresis", 32'(throttled[0]), 32'd1);
    setTemps(79, 40, 40);
    idle(6);

    doReset();
    setTemps(95, 95, 95);
    for (int i = 0; i < 4; i++) applyStimulus(1, 3);
    checkOutput("s4 halted", 32'(halted), 32'd1);
    checkOutput("s4 not ready", 32'(job_ready), 32'd0);
    setTemps(95, 95, 70);
    for (int i = 0; i < 3; i++) applyStimulus(1, 3);
    checkOutput("s4 core2 run", 32'(in_use), 32'b100);
    idle(4);

    doReset();
    setTemps(40, 40, 40);
    applyStimulus(1, 0);
    checkOutput("s5 one cycle", 32'(in_use), 32'b001);
    applyStimulus(0, 0);
    checkOutput("s5 done", 32'(done_pulse), 32'b001);
    idle(1);

    doReset();
    setTemps(40, 40, 40);
    for (int i = 0; i < 3; i++) applyStimulus(1, 20);
    checkOutput("s6 all busy", 32'(in_use), 32'b111);
    doReset();
    idle(25);

    doReset();
    setTemps(70, 70, 70);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) tempIn[$urandom_range(0, N-1)] = $urandom_range(60, 100);
      if ($urandom_range(0, 40) == 0) setTemps(95, 96, 97);
      applyStimulus(bit'($urandom_range(0, 1)), $urandom_range(0, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
